// File: rtl/rob_param_if.sv
// Reorder-buffer bundle: dispatch, two writeback ports, operand queries,
// store handshake, commit and control outputs. master = core side, slave = ROB.
interface rob_param_if #(
  parameter int DEPTH = 16,
  parameter int IDW   = 4,
  parameter int XLEN  = 32
);
  logic            disp_valid;
  logic            disp_ready;
  logic [XLEN-1:0] disp_pc;
  logic [4:0]      disp_rd;
  logic            disp_is_br;
  logic            disp_pred_taken;
  logic            disp_is_store;
  logic [IDW-1:0]  disp_id;

  logic            wb0_valid;
  logic [IDW-1:0]  wb0_id;
  logic [XLEN-1:0] wb0_res;
  logic            wb0_taken;
  logic [XLEN-1:0] wb0_target;

  logic            wb1_valid;
  logic [IDW-1:0]  wb1_id;
  logic [XLEN-1:0] wb1_res;

  logic [IDW-1:0]  q1_id;
  logic [IDW-1:0]  q2_id;
  logic            q1_ready;
  logic            q2_ready;
  logic [XLEN-1:0] q1_val;
  logic [XLEN-1:0] q2_val;

  logic            st_commit;
  logic [IDW-1:0]  st_commit_id;
  logic            st_ack;

  logic            cm_valid;
  logic [4:0]      cm_rd;
  logic [XLEN-1:0] cm_res;
  logic [IDW-1:0]  cm_id;

  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            bp_valid;
  logic [XLEN-1:0] bp_pc;
  logic            bp_taken;
  logic [IDW:0]    count;

  modport master (
    output disp_valid, disp_pc, disp_rd, disp_is_br, disp_pred_taken, disp_is_store,
    output wb0_valid, wb0_id, wb0_res, wb0_taken, wb0_target,
    output wb1_valid, wb1_id, wb1_res,
    output q1_id, q2_id, st_ack,
    input  disp_ready, disp_id, q1_ready, q2_ready, q1_val, q2_val,
    input  st_commit, st_commit_id, cm_valid, cm_rd, cm_res, cm_id,
    input  flush, flush_pc, bp_valid, bp_pc, bp_taken, count
  );

  modport slave (
    input  disp_valid, disp_pc, disp_rd, disp_is_br, disp_pred_taken, disp_is_store,
    input  wb0_valid, wb0_id, wb0_res, wb0_taken, wb0_target,
    input  wb1_valid, wb1_id, wb1_res,
    input  q1_id, q2_id, st_ack,
    output disp_ready, disp_id, q1_ready, q2_ready, q1_val, q2_val,
    output st_commit, st_commit_id, cm_valid, cm_rd, cm_res, cm_id,
    output flush, flush_pc, bp_valid, bp_pc, bp_taken, count
  );
endinterface

// File: rtl/rob_param.sv
// In-order-commit reorder buffer, one commit/cycle, registered commit/flush outputs.
// ROB_WB_BYPASS_EN: operand queries also see same-cycle writebacks (wb0 priority).
module rob_param #(
  parameter int DEPTH = 16,
  parameter int IDW   = 4,
  parameter int XLEN  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  rob_param_if.slave bus
);
  localparam int CW = IDW + 1;

  logic [IDW-1:0]   head, tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ready_q, ready_nxt;

  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [XLEN-1:0]  res_q [DEPTH];
  logic [XLEN-1:0]  tg_q  [DEPTH];
  logic [DEPTH-1:0] br_q, pt_q, st_q, tk_q;

  logic             cm_valid_q, bp_valid_q, bp_taken_q, flush_q;
  logic [4:0]       cm_rd_q;
  logic [IDW-1:0]   cm_id_q;
  logic [XLEN-1:0]  cm_res_q, bp_pc_q, flush_pc_q;

  logic full, empty, disp_fire, cm_fire, head_mispredict;

  assign full            = count == CW'(DEPTH);
  assign empty           = count == '0;
  assign disp_fire       = rdy & bus.disp_valid & ~full & ~flush_q;
  assign cm_fire         = rdy & ~flush_q & ~empty & ready_q[head] & (~st_q[head] | bus.st_ack);
  assign head_mispredict = br_q[head] & (tk_q[head] ^ pt_q[head]);

  assign bus.disp_ready   = ~full & ~flush_q;
  assign bus.disp_id      = tail;
  assign bus.st_commit    = ~empty & st_q[head] & ready_q[head] & ~flush_q;
  assign bus.st_commit_id = head;
  assign bus.count        = count;
  assign bus.cm_valid     = cm_valid_q;
  assign bus.cm_rd        = cm_rd_q;
  assign bus.cm_res       = cm_res_q;
  assign bus.cm_id        = cm_id_q;
  assign bus.bp_valid     = bp_valid_q;
  assign bus.bp_pc        = bp_pc_q;
  assign bus.bp_taken     = bp_taken_q;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;

  // wb1 first so wb0 wins on a shared id; a newly dispatched slot starts not-ready
  always_comb begin
    ready_nxt = ready_q;
    if (bus.wb1_valid) ready_nxt[bus.wb1_id] = 1'b1;
    if (bus.wb0_valid) ready_nxt[bus.wb0_id] = 1'b1;
    if (disp_fire)     ready_nxt[tail]       = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ready_q    <= '0;
      cm_valid_q <= 1'b0;
      cm_rd_q    <= '0;
      cm_res_q   <= '0;
      cm_id_q    <= '0;
      bp_valid_q <= 1'b0;
      bp_pc_q    <= '0;
      bp_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy) begin
      if (flush_q) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        ready_q    <= '0;
        cm_valid_q <= 1'b0;
        bp_valid_q <= 1'b0;
        flush_q    <= 1'b0;
      end else begin
        ready_q    <= ready_nxt;
        cm_valid_q <= cm_fire;
        bp_valid_q <= cm_fire & br_q[head];
        flush_q    <= cm_fire & head_mispredict;
        if (disp_fire) tail <= tail + 1'b1;
        if (cm_fire) begin
          head     <= head + 1'b1;
          cm_rd_q  <= rd_q[head];
          cm_res_q <= res_q[head];
          cm_id_q  <= head;
          if (br_q[head]) begin
            bp_pc_q    <= pc_q[head];
            bp_taken_q <= tk_q[head];
          end
          if (head_mispredict)
            flush_pc_q <= tk_q[head] ? tg_q[head] : pc_q[head] + XLEN'(4);
        end
        unique case ({disp_fire, cm_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload needs no reset: every read is qualified by a ready bit
  always_ff @(posedge clk) begin
    if (rdy && !flush_q) begin
      if (disp_fire) begin
        pc_q[tail] <= bus.disp_pc;
        rd_q[tail] <= bus.disp_rd;
        br_q[tail] <= bus.disp_is_br;
        pt_q[tail] <= bus.disp_pred_taken;
        st_q[tail] <= bus.disp_is_store;
      end
      if (bus.wb1_valid) res_q[bus.wb1_id] <= bus.wb1_res;
      if (bus.wb0_valid) begin
        res_q[bus.wb0_id] <= bus.wb0_res;
        tk_q[bus.wb0_id]  <= bus.wb0_taken;
        tg_q[bus.wb0_id]  <= bus.wb0_target;
      end
    end
  end

  always_comb begin
    bus.q1_ready = ready_q[bus.q1_id];
    bus.q1_val   = res_q[bus.q1_id];
    bus.q2_ready = ready_q[bus.q2_id];
    bus.q2_val   = res_q[bus.q2_id];
`ifdef ROB_WB_BYPASS_EN
    if (bus.wb1_valid && bus.wb1_id == bus.q1_id) begin
      bus.q1_ready = 1'b1;
      bus.q1_val   = bus.wb1_res;
    end
    if (bus.wb0_valid && bus.wb0_id == bus.q1_id) begin
      bus.q1_ready = 1'b1;
      bus.q1_val   = bus.wb0_res;
    end
    if (bus.wb1_valid && bus.wb1_id == bus.q2_id) begin
      bus.q2_ready = 1'b1;
      bus.q2_val   = bus.wb1_res;
    end
    if (bus.wb0_valid && bus.wb0_id == bus.q2_id) begin
      bus.q2_ready = 1'b1;
      bus.q2_val   = bus.wb0_res;
    end
`endif
  end
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus random traffic against a queue-based model;
// a second DEPTH=4 instance exercises tag wrap at full occupancy.
module tb_rob_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  rob_param_if #(.DEPTH(16), .IDW(4), .XLEN(32)) bus ();
  rob_param_if #(.DEPTH(4),  .IDW(2), .XLEN(32)) bus4 ();

  rob_param #(.DEPTH(16), .IDW(4), .XLEN(32)) dut  (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  rob_param #(.DEPTH(4),  .IDW(2), .XLEN(32)) dut4 (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus4));

  typedef struct {
    bit rdy; bit dv; logic [31:0] pc; logic [4:0] rd; bit br; bit pt; bit st;
    bit w0v; logic [3:0] w0id; logic [31:0] w0res; bit w0tk; logic [31:0] w0tg;
    bit w1v; logic [3:0] w1id; logic [31:0] w1res;
    logic [3:0] q1; logic [3:0] q2; bit ack;
  } stim_t;

  typedef struct { logic [3:0] id; logic [31:0] pc; logic [4:0] rd; bit br; bit pt; bit st; } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: in-flight entries in program order plus per-tag result state
  ent_t        mq[$];
  logic [3:0]  m_tail;
  bit          m_rdy [16];
  logic [31:0] m_res [16];
  bit          m_tk  [16];
  logic [31:0] m_tg  [16];
  bit          m_flush, m_cmv, m_bpv, m_bptk;
  logic [31:0] m_flush_pc, m_cmres, m_bppc;
  logic [4:0]  m_cmrd;
  logic [3:0]  m_cmid;

  logic        o_disp_ready, o_st_commit, o_q1_ready;
  logic [3:0]  o_disp_id;
  logic [31:0] o_q1_val;
  logic        o4_disp_ready;
  logic [1:0]  o4_disp_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail = '0;
    for (int i = 0; i < 16; i++) begin m_rdy[i] = 1'b0; m_tk[i] = 1'b0; end
    m_flush = 0; m_cmv = 0; m_bpv = 0; m_bptk = 0;
    m_flush_pc = '0; m_cmres = '0; m_bppc = '0; m_cmrd = '0; m_cmid = '0;
  endtask

  task automatic model_step(input stim_t s);
    ent_t h;
    bit commit, accept;
    if (!s.rdy) return;
    if (m_flush) begin
      mq.delete();
      m_tail = '0;
      for (int i = 0; i < 16; i++) m_rdy[i] = 1'b0;
      m_flush = 0; m_cmv = 0; m_bpv = 0;
      return;
    end
    commit = 0;
    if (mq.size() > 0) begin
      h = mq[0];
      commit = m_rdy[h.id] && (!h.st || s.ack);
    end
    accept = s.dv && (mq.size() < 16);
    m_cmv = commit;
    m_bpv = commit && h.br;
    if (commit) begin
      m_cmrd = h.rd; m_cmres = m_res[h.id]; m_cmid = h.id;
      if (h.br) begin
        m_bppc = h.pc; m_bptk = m_tk[h.id];
        if (m_tk[h.id] != h.pt) begin
          m_flush = 1;
          m_flush_pc = m_tk[h.id] ? m_tg[h.id] : h.pc + 32'd4;
        end
      end
      void'(mq.pop_front());
    end
    if (s.w1v) begin m_rdy[s.w1id] = 1; m_res[s.w1id] = s.w1res; end
    if (s.w0v) begin
      m_rdy[s.w0id] = 1; m_res[s.w0id] = s.w0res; m_tk[s.w0id] = s.w0tk; m_tg[s.w0id] = s.w0tg;
    end
    if (accept) begin
      mq.push_back('{id: m_tail, pc: s.pc, rd: s.rd, br: s.br, pt: s.pt, st: s.st});
      m_rdy[m_tail] = 0;
      m_tail = m_tail + 4'd1;
    end
  endtask

  task automatic exp_query(input logic [3:0] id, input stim_t s, output bit r, output logic [31:0] v);
    r = m_rdy[id];
    v = m_res[id];
`ifdef ROB_WB_BYPASS_EN
    if (s.w1v && s.w1id == id) begin r = 1; v = s.w1res; end
    if (s.w0v && s.w0id == id) begin r = 1; v = s.w0res; end
`endif
  endtask

  task automatic run_cycle(input stim_t s);
    bit er; logic [31:0] ev; bit est;
    @(negedge clk);
    rdy = s.rdy;
    bus.disp_valid = s.dv; bus.disp_pc = s.pc; bus.disp_rd = s.rd;
    bus.disp_is_br = s.br; bus.disp_pred_taken = s.pt; bus.disp_is_store = s.st;
    bus.wb0_valid = s.w0v; bus.wb0_id = s.w0id; bus.wb0_res = s.w0res;
    bus.wb0_taken = s.w0tk; bus.wb0_target = s.w0tg;
    bus.wb1_valid = s.w1v; bus.wb1_id = s.w1id; bus.wb1_res = s.w1res;
    bus.q1_id = s.q1; bus.q2_id = s.q2; bus.st_ack = s.ack;
    #1;
    o_disp_ready = bus.disp_ready; o_disp_id = bus.disp_id; o_st_commit = bus.st_commit;
    o_q1_ready = bus.q1_ready; o_q1_val = bus.q1_val;
    check("disp_ready", bus.disp_ready, (mq.size() < 16) && !m_flush);
    check("disp_id", bus.disp_id, m_tail);
    check("count", bus.count, mq.size());
    est = 0;
    if (mq.size() > 0) begin
      est = mq[0].st && m_rdy[mq[0].id] && !m_flush;
      check("st_commit_id", bus.st_commit_id, mq[0].id);
    end
    check("st_commit", bus.st_commit, est);
    exp_query(s.q1, s, er, ev);
    check("q1_ready", bus.q1_ready, er);
    if (er) check("q1_val", bus.q1_val, ev);
    exp_query(s.q2, s, er, ev);
    check("q2_ready", bus.q2_ready, er);
    if (er) check("q2_val", bus.q2_val, ev);
    model_step(s);
    @(posedge clk);
    #1;
    check("cm_valid", bus.cm_valid, m_cmv);
    if (m_cmv) begin
      check("cm_rd", bus.cm_rd, m_cmrd);
      check("cm_res", bus.cm_res, m_cmres);
      check("cm_id", bus.cm_id, m_cmid);
    end
    check("bp_valid", bus.bp_valid, m_bpv);
    if (m_bpv) begin
      check("bp_pc", bus.bp_pc, m_bppc);
      check("bp_taken", bus.bp_taken, m_bptk);
    end
    check("flush", bus.flush, m_flush);
    if (m_flush) check("flush_pc", bus.flush_pc, m_flush_pc);
    check("count_post", bus.count, mq.size());
  endtask

  task automatic drive_idle();
    rdy = 1'b1;
    bus.disp_valid = 0; bus.disp_pc = '0; bus.disp_rd = '0; bus.disp_is_br = 0;
    bus.disp_pred_taken = 0; bus.disp_is_store = 0;
    bus.wb0_valid = 0; bus.wb0_id = '0; bus.wb0_res = '0; bus.wb0_taken = 0; bus.wb0_target = '0;
    bus.wb1_valid = 0; bus.wb1_id = '0; bus.wb1_res = '0;
    bus.q1_id = '0; bus.q2_id = '0; bus.st_ack = 0;
    bus4.disp_valid = 0; bus4.disp_pc = '0; bus4.disp_rd = '0; bus4.disp_is_br = 0;
    bus4.disp_pred_taken = 0; bus4.disp_is_store = 0;
    bus4.wb0_valid = 0; bus4.wb0_id = '0; bus4.wb0_res = '0; bus4.wb0_taken = 0; bus4.wb0_target = '0;
    bus4.wb1_valid = 0; bus4.wb1_id = '0; bus4.wb1_res = '0;
    bus4.q1_id = '0; bus4.q2_id = '0; bus4.st_ack = 0;
  endtask

  // reset lands mid-cycle, away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_cm_valid", bus.cm_valid, 0);
    check("rst_bp_valid", bus.bp_valid, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_flush_pc", bus.flush_pc, 0);
    check("rst_count", bus.count, 0);
    check("rst_cm_id", bus.cm_id, 0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic drv4(input bit dv, input bit w0v, input logic [1:0] w0id);
    @(negedge clk);
    bus4.disp_valid = dv; bus4.wb0_valid = w0v; bus4.wb0_id = w0id; bus4.wb0_res = {30'd0, w0id};
    bus4.disp_rd = 5'd3;
    #1;
    o4_disp_ready = bus4.disp_ready;
    o4_disp_id = bus4.disp_id;
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycle(input int wbp);
    stim_t s;
    int idx;
    s = idle();
    s.rdy = ($urandom_range(0, 9) != 0);
    s.dv  = ($urandom_range(0, 2) != 0);
    s.pc  = $urandom; s.rd = 5'($urandom);
    s.br  = ($urandom_range(0, 11) == 0);
    s.pt  = 1'($urandom);
    s.st  = !s.br && ($urandom_range(0, 4) == 0);
    if (mq.size() > 0 && $urandom_range(0, 99) < wbp) begin
      idx = $urandom_range(0, mq.size() - 1);
      s.w0v = 1; s.w0id = mq[idx].id; s.w0res = $urandom; s.w0tk = 1'($urandom); s.w0tg = $urandom;
    end
    if (mq.size() > 0 && $urandom_range(0, 99) < wbp) begin
      idx = $urandom_range(0, mq.size() - 1);
      // branches are only completed through the ALU port
      if (!mq[idx].br) begin s.w1v = 1; s.w1id = mq[idx].id; s.w1res = $urandom; end
    end
    s.q1 = 4'($urandom); s.q2 = 4'($urandom);
    s.ack = 1'($urandom);
    run_cycle(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    drive_idle();
    model_reset();
    do_reset();

    // fill to capacity, then one refused dispatch
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.dv = 1; s.pc = 32'(i * 4); s.rd = 5'(i);
      run_cycle(s);
      check("fill_id", o_disp_id, i);
    end
    check("full_count", bus.count, 16);
    s = idle(); s.dv = 1;
    run_cycle(s);
    check("full_disp_ready", o_disp_ready, 0);
    check("refused_count", bus.count, 16);

    // out-of-order completion, in-order commit
    s = idle(); s.w0v = 1; s.w0id = 2; s.w0res = 32'h55;
    run_cycle(s);
    check("ooo_no_commit", bus.cm_valid, 0);
    s = idle(); s.w0v = 1; s.w0id = 0; s.w0res = 32'h10; s.w1v = 1; s.w1id = 1; s.w1res = 32'h11;
    run_cycle(s);
    check("ooo_no_commit2", bus.cm_valid, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(idle());
      check("ooo_cm_valid", bus.cm_valid, 1);
      check("ooo_cm_id", bus.cm_id, i);
    end
    check("ooo_cm_res2", bus.cm_res, 32'h55);

    // store waits for acknowledge
    do_reset();
    s = idle(); s.dv = 1; s.st = 1; s.rd = 5'd7;
    run_cycle(s);
    s = idle(); s.w1v = 1; s.w1id = 0; s.w1res = 32'h77;
    run_cycle(s);
    for (int i = 0; i < 3; i++) begin
      run_cycle(idle());
      check("st_wait_commit", o_st_commit, 1);
      check("st_wait_no_cm", bus.cm_valid, 0);
    end
    s = idle(); s.ack = 1;
    run_cycle(s);
    check("st_ack_commit", o_st_commit, 1);
    check("st_ack_cm", bus.cm_valid, 1);
    check("st_ack_res", bus.cm_res, 32'h77);

    // mispredicted taken branch
    do_reset();
    s = idle(); s.dv = 1; s.br = 1; s.pt = 0; s.pc = 32'h100;
    run_cycle(s);
    s = idle(); s.w0v = 1; s.w0id = 0; s.w0tk = 1; s.w0tg = 32'h200;
    run_cycle(s);
    run_cycle(idle());
    check("br_bp_valid", bus.bp_valid, 1);
    check("br_bp_pc", bus.bp_pc, 32'h100);
    check("br_bp_taken", bus.bp_taken, 1);
    check("br_flush", bus.flush, 1);
    check("br_flush_pc", bus.flush_pc, 32'h200);
    s = idle(); s.dv = 1;
    run_cycle(s);
    check("br_flush_blocks", o_disp_ready, 0);
    check("br_flush_drop", bus.flush, 0);
    check("br_flush_count", bus.count, 0);
    s = idle(); s.dv = 1;
    run_cycle(s);
    check("br_post_id", o_disp_id, 0);

    // reset while a not-taken mispredict flush is pending
    do_reset();
    s = idle(); s.dv = 1; s.br = 1; s.pt = 1; s.pc = 32'h300;
    run_cycle(s);
    s = idle(); s.w0v = 1; s.w0id = 0; s.w0tk = 0; s.w0tg = 32'h999;
    run_cycle(s);
    run_cycle(idle());
    check("nt_flush_pc", bus.flush_pc, 32'h304);
    do_reset();
    s = idle(); s.dv = 1;
    run_cycle(s);
    check("rst_first_id", o_disp_id, 0);

    // same-cycle writeback seen by an operand query
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.dv = 1; s.rd = 5'(i);
      run_cycle(s);
    end
    s = idle(); s.w1v = 1; s.w1id = 5; s.w1res = 32'h9; s.q1 = 5;
    run_cycle(s);
`ifdef ROB_WB_BYPASS_EN
    check("byp_q1_ready", o_q1_ready, 1);
    check("byp_q1_val", o_q1_val, 32'h9);
`else
    check("byp_q1_ready", o_q1_ready, 0);
`endif
    s = idle(); s.q1 = 5;
    run_cycle(s);
    check("stored_q1_ready", o_q1_ready, 1);
    check("stored_q1_val", o_q1_val, 32'h9);

    // DEPTH=4: commit/refill pairs at full, tags wrap 3 -> 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv4(1, 0, 2'd0);
      check("w4_fill_id", o4_disp_id, i);
    end
    check("w4_full_count", bus4.count, 4);
    for (int i = 0; i < 10; i++) begin
      drv4(1, 1, 2'(i % 4));
      check("w4_full_rdy", o4_disp_ready, 0);
      drv4(1, 0, 2'd0);
      check("w4_cm_valid", bus4.cm_valid, 1);
      check("w4_cm_id", bus4.cm_id, i % 4);
      drv4(1, 0, 2'd0);
      check("w4_refill_id", o4_disp_id, i % 4);
      check("w4_count", bus4.count, 4);
    end

    // random traffic, writeback density ramps up so the buffer both fills and drains
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 600; c++)
        random_cycle(15 + p * 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
